// File: rtl/qspi_boot_reader.sv
// SPI-mode-0 boot reader: issues READ_CMD + 24-bit address, streams 32-bit little-endian words.
// Latency: word valid one clk after its 32nd SCK sample; backpressure freezes SCK low (STALL) until ready_i.
module qspi_boot_reader #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [23:0] start_addr_i,
  input  logic [15:0] word_cnt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        qspi_clk_o,
  output logic        qspi_csn_o,
  output logic        qspi_sdo_o,
  input  logic        qspi_sdi_i,
  output logic        qspi_wpn_o,
  output logic        qspi_holdn_o
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STALL, DRAIN, GAP} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nx;
  logic [7:0]  div_cnt;
  logic        sck;
  logic [4:0]  bit_cnt;
  logic [31:0] tx_sr, rx_sr, data_q;
  logic [15:0] words_left, gap_cnt;
  logic        pend, valid_q, done_q, csn_q;
  logic        accept, accept_run, tick, shifting, sck_run, rise, fall;
  logic        hs, out_free, load, last_sample, gap_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_run) state_nx = CMD;
      CMD:     if (fall && bit_cnt == 5'd7) state_nx = ADDR;
      ADDR:    if (fall && bit_cnt == 5'd31) state_nx = DATA;
      DATA: begin
        if (pend) begin
          if (words_left == 16'd0) state_nx = DRAIN;
          else if (!out_free)      state_nx = STALL;
        end
      end
      STALL:   if (out_free) state_nx = DATA;
      DRAIN:   if (!pend && hs) state_nx = GAP;
      GAP:     if (gap_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept      = (state == IDLE) && start_i;
    accept_run  = accept && (word_cnt_i != 16'd0);
    tick        = (div_cnt == DIV_LAST);
    shifting    = state inside {CMD, ADDR, DATA};
    // A STALL entered mid high-phase finishes that half-period before parking SCK low.
    sck_run     = shifting || (state == STALL && sck);
    rise        = shifting && !sck && tick;
    fall        = sck_run && sck && tick;
    hs          = valid_q && ready_i;
    out_free    = !valid_q || ready_i;
    load        = pend && out_free && (state inside {DATA, STALL, DRAIN});
    last_sample = rise && (state == DATA) && (bit_cnt == 5'd31);
    gap_done    = (32'(gap_cnt) + 32'd1) >= CS_GAP;
    busy_o      = state inside {CMD, ADDR, DATA, STALL, DRAIN};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      sck        <= 1'b0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      data_q     <= '0;
      words_left <= '0;
      gap_cnt    <= '0;
      pend       <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      csn_q      <= 1'b1;
    end else begin
      csn_q  <= !(state_nx inside {CMD, ADDR, DATA, STALL});
      done_q <= (accept && word_cnt_i == 16'd0) || (state == DRAIN && !pend && hs);
      if (sck_run && state_nx != DRAIN) begin
        if (tick) begin
          div_cnt <= '0;
          sck     <= !sck;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end else begin
        div_cnt <= '0;
        sck     <= 1'b0;
      end
      if (accept_run) tx_sr <= {READ_CMD, start_addr_i};
      else if (fall)  tx_sr <= {tx_sr[30:0], 1'b0};
      // bit_cnt wraps 31->0 at the CMD/ADDR to DATA boundary and again per word.
      if (accept_run) bit_cnt <= '0;
      else if ((fall && state inside {CMD, ADDR}) || (rise && state == DATA))
        bit_cnt <= bit_cnt + 5'd1;
      if (rise && state == DATA) rx_sr <= {rx_sr[30:0], qspi_sdi_i};
      if (accept_run)       words_left <= word_cnt_i;
      else if (last_sample) words_left <= words_left - 16'd1;
      if (last_sample) pend <= 1'b1;
      else if (load)   pend <= 1'b0;
      if (load) begin
        data_q  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
      if (state != DRAIN && state_nx == DRAIN) gap_cnt <= '0;
      else if (state inside {DRAIN, GAP} && gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;
    end
  end

  assign done_o       = done_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign qspi_clk_o   = sck;
  assign qspi_csn_o   = csn_q;
  assign qspi_sdo_o   = tx_sr[31];
  assign qspi_wpn_o   = 1'b1;
  assign qspi_holdn_o = 1'b1;
endmodule

// File: tb/tb_qspi_boot_reader.sv
// Directed bench for qspi_boot_reader: default-parameter instance plus a CLK_DIV=3 instance
// sharing one behavioural SPI flash through a select mux.
module tb_qspi_boot_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, ready = 1'b1, sel = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] cnt = '0;
  logic f_sdi = 1'b0;

  logic a_busy, a_done, a_valid, a_sck, a_csn, a_sdo, a_wpn, a_holdn;
  logic b_busy, b_done, b_valid, b_sck, b_csn, b_sdo, b_wpn, b_holdn;
  logic [31:0] a_data, b_data;

  qspi_boot_reader dut (
    .clk(clk), .rst(rst), .start_i(start & ~sel), .start_addr_i(addr), .word_cnt_i(cnt),
    .busy_o(a_busy), .done_o(a_done), .data_o(a_data), .valid_o(a_valid), .ready_i(ready),
    .qspi_clk_o(a_sck), .qspi_csn_o(a_csn), .qspi_sdo_o(a_sdo), .qspi_sdi_i(f_sdi),
    .qspi_wpn_o(a_wpn), .qspi_holdn_o(a_holdn));

  qspi_boot_reader #(.CLK_DIV(3)) dut_d3 (
    .clk(clk), .rst(rst), .start_i(start & sel), .start_addr_i(addr), .word_cnt_i(cnt),
    .busy_o(b_busy), .done_o(b_done), .data_o(b_data), .valid_o(b_valid), .ready_i(ready),
    .qspi_clk_o(b_sck), .qspi_csn_o(b_csn), .qspi_sdo_o(b_sdo), .qspi_sdi_i(f_sdi),
    .qspi_wpn_o(b_wpn), .qspi_holdn_o(b_holdn));

  logic f_busy, f_done, f_valid, f_sck, f_csn, f_sdo, f_wpn, f_holdn;
  logic [31:0] f_data;
  assign f_busy  = sel ? b_busy  : a_busy;
  assign f_done  = sel ? b_done  : a_done;
  assign f_valid = sel ? b_valid : a_valid;
  assign f_sck   = sel ? b_sck   : a_sck;
  assign f_csn   = sel ? b_csn   : a_csn;
  assign f_sdo   = sel ? b_sdo   : a_sdo;
  assign f_wpn   = sel ? b_wpn   : a_wpn;
  assign f_holdn = sel ? b_holdn : a_holdn;
  assign f_data  = sel ? b_data  : a_data;

  // Flash model: 1 KiB image, bytes 0x100..0x107 = 11..88, the rest a ^ 0xA5.
  logic [7:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 8; i++) mem[256 + i] = 8'(8'h11 * (i + 1));
  end

  logic [31:0] si_sr = '0;
  int rise_cnt = 0, last_rises = 0, fd = 0, fidx = 0;
  always @(posedge f_sck or posedge f_csn) begin
    if (f_csn === 1'b1) begin
      last_rises = rise_cnt;
      rise_cnt = 0;
    end else begin
      if (rise_cnt < 32) si_sr = {si_sr[30:0], f_sdo};
      rise_cnt++;
    end
  end
  always @(negedge f_sck) begin
    if (f_csn === 1'b0 && rise_cnt >= 32) begin
      fd = rise_cnt - 32;
      fidx = (int'(si_sr[23:0]) + fd / 8) % 1024;
      f_sdi = mem[fidx][7 - (fd % 8)];
    end
  end

  // Bus monitors; sampled at posedge so they see the values of the cycle just ended.
  logic [31:0] got[$];
  int done_cnt = 0, valid_seen = 0, csn_low_seen = 0, hi_run = 0, last_hi_run = 0;
  int sdo_viol = 0, run = 0, tim_bad = 0, tim_n = 0;
  bit tim_en = 1'b0;
  logic m_sdo = 1'b0, m_sck = 1'b0, m_csn = 1'b1;
  always @(posedge clk) begin
    if (f_valid === 1'b1 && ready === 1'b1) got.push_back(f_data);
    if (f_done === 1'b1) done_cnt++;
    if (f_valid === 1'b1) valid_seen++;
    if (f_csn === 1'b0) csn_low_seen++;
    if (f_csn === 1'b1) hi_run++;
    else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end
    if (f_sdo !== m_sdo && f_sck === 1'b1 && m_sck === 1'b1) sdo_viol++;
    if (f_csn === 1'b0) begin
      if (f_sck !== m_sck && m_csn === 1'b0) begin
        if (tim_en) begin
          tim_n++;
          if (run != 3) tim_bad++;
        end
        run = 1;
      end else run++;
    end else run = 0;
    m_sdo = f_sdo; m_sck = f_sck; m_csn = f_csn;
  end

  int checks = 0, errors = 0;

  function automatic logic [31:0] gw(input int i);
    return (i < got.size()) ? got[i] : 32'hxxxxxxxx;
  endfunction

  task automatic issue(input logic [23:0] a, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1; addr = a; cnt = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit to);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    to = (done_cnt < target);
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; start = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (f_csn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b want 1", f_csn); end
    checks++; if (f_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", f_sck); end
    checks++; if (f_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", f_sdo); end
    checks++; if (f_valid !== 1'b0 || f_data !== 32'h0) begin errors++; $display("FAIL reset_out: valid %b data %h want 0/0", f_valid, f_data); end
    checks++; if (f_busy !== 1'b0 || f_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: %b %b want 0 0", f_busy, f_done); end
    checks++; if (f_wpn !== 1'b1 || f_holdn !== 1'b1 || b_wpn !== 1'b1 || b_holdn !== 1'b1) begin errors++; $display("FAIL reset_wp_hold: %b%b%b%b want 1111", f_wpn, f_holdn, b_wpn, b_holdn); end
    checks++; if (b_csn !== 1'b1 || b_sck !== 1'b0) begin errors++; $display("FAIL reset_d3: csn %b sck %b want 1 0", b_csn, b_sck); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int g0 = got.size(), d0 = done_cnt;
    bit to;
    sel = 1'b0; ready = 1'b1;
    issue(24'h000100, 16'd2);
    checks++; if (f_busy !== 1'b1 || f_csn !== 1'b0) begin errors++; $display("FAIL basic_accept: busy %b csn %b want 1 0", f_busy, f_csn); end
    wait_done(d0 + 1, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: done %0d want %0d", done_cnt - d0, 1); end
    checks++; if (gw(g0) !== 32'h44332211) begin errors++; $display("FAIL basic_w0: got %h want 44332211", gw(g0)); end
    checks++; if (gw(g0 + 1) !== 32'h88776655) begin errors++; $display("FAIL basic_w1: got %h want 88776655", gw(g0 + 1)); end
    checks++; if (si_sr !== 32'h03000100) begin errors++; $display("FAIL basic_si: got %h want 03000100", si_sr); end
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", f_busy); end
    repeat (10) @(negedge clk);
    checks++; if (got.size() - g0 != 2 || done_cnt - d0 != 1) begin errors++; $display("FAIL basic_counts: words %0d done %0d want 2 1", got.size() - g0, done_cnt - d0); end
    checks++; if (sdo_viol != 0) begin errors++; $display("FAIL basic_sdo_mode0: changes while SCK high %0d want 0", sdo_viol); end
  endtask

  task automatic test_clk_div3;
    int g0 = got.size(), d0 = done_cnt, t0 = tim_n, b0 = tim_bad;
    bit to;
    sel = 1'b1; ready = 1'b1; tim_en = 1'b1;
    issue(24'h000104, 16'd1);
    wait_done(d0 + 1, 3000, to);
    tim_en = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL div3_timeout: done %0d want 1", done_cnt - d0); end
    checks++; if (last_rises != 64) begin errors++; $display("FAIL div3_rises: got %0d want 64", last_rises); end
    checks++; if (tim_bad != b0 || tim_n - t0 < 120) begin errors++; $display("FAIL div3_halfperiod: bad %0d checked %0d want 0 >=120", tim_bad - b0, tim_n - t0); end
    checks++; if (gw(g0) !== 32'h88776655) begin errors++; $display("FAIL div3_word: got %h want 88776655", gw(g0)); end
    checks++; if (si_sr !== 32'h03000104) begin errors++; $display("FAIL div3_si: got %h want 03000104", si_sr); end
    repeat (10) @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_stall;
    int g0 = got.size(), d0 = done_cnt, n = 0, stab_bad = 0, csn_bad = 0, r150 = 0, r200 = 0;
    logic [31:0] dq;
    bit to;
    sel = 1'b0; ready = 1'b0;
    issue(24'h000100, 16'd3);
    while (f_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL stall_first_valid: got %b want 1", f_valid); end
    dq = f_data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (f_valid !== 1'b1 || f_data !== dq) stab_bad++;
      if (f_csn !== 1'b0) csn_bad++;
      if (i == 150) r150 = rise_cnt;
    end
    r200 = rise_cnt;
    checks++; if (dq !== 32'h44332211) begin errors++; $display("FAIL stall_held_word: got %h want 44332211", dq); end
    checks++; if (stab_bad != 0) begin errors++; $display("FAIL stall_stable: unstable cycles %0d want 0", stab_bad); end
    checks++; if (csn_bad != 0) begin errors++; $display("FAIL stall_csn: high cycles %0d want 0", csn_bad); end
    checks++; if (r150 != 96 || r200 != 96) begin errors++; $display("FAIL stall_sck_frozen: rises %0d/%0d want 96/96", r150, r200); end
    ready = 1'b1;
    wait_done(d0 + 1, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout: done %0d want 1", done_cnt - d0); end
    checks++; if (gw(g0) !== 32'h44332211 || gw(g0 + 1) !== 32'h88776655 || gw(g0 + 2) !== 32'hAEAFACAD) begin
      errors++; $display("FAIL stall_order: got %h %h %h want 44332211 88776655 aeafacad", gw(g0), gw(g0 + 1), gw(g0 + 2)); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_zero;
    int c0 = csn_low_seen, v0 = valid_seen, d0 = done_cnt;
    sel = 1'b0; ready = 1'b1;
    issue(24'h000100, 16'd0);
    checks++; if (f_done !== 1'b1 || f_busy !== 1'b0 || f_csn !== 1'b1) begin errors++; $display("FAIL zero_accept: done %b busy %b csn %b want 1 0 1", f_done, f_busy, f_csn); end
    @(negedge clk);
    checks++; if (f_done !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: got %b want 0", f_done); end
    repeat (10) @(negedge clk);
    checks++; if (csn_low_seen != c0 || valid_seen != v0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL zero_quiet: csn_low %0d valid %0d done %0d want 0 0 1", csn_low_seen - c0, valid_seen - v0, done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int n = 0, g0, d0;
    bit to;
    sel = 1'b0; ready = 1'b1;
    issue(24'h000100, 16'd2);
    while (rise_cnt < 16 && n < 500) begin @(negedge clk); n++; end
    checks++; if (rise_cnt < 16 || rise_cnt >= 32) begin errors++; $display("FAIL rstmid_reach_addr: rises %0d want 16..31", rise_cnt); end
    g0 = got.size(); d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (f_csn !== 1'b1 || f_sck !== 1'b0 || f_busy !== 1'b0 || f_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: csn %b sck %b busy %b valid %b want 1 0 0 0", f_csn, f_sck, f_busy, f_valid); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(24'h000104, 16'd1);
    wait_done(d0 + 1, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_timeout: done %0d want 1", done_cnt - d0); end
    @(negedge clk);
    checks++; if (got.size() - g0 != 1 || gw(g0) !== 32'h88776655 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL rstmid_restart: words %0d w0 %h done %0d want 1 88776655 1", got.size() - g0, gw(g0), done_cnt - d0); end
    checks++; if (si_sr !== 32'h03000104) begin errors++; $display("FAIL rstmid_si: got %h want 03000104", si_sr); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n = 0, g0 = got.size(), d0 = done_cnt;
    bit to;
    sel = 1'b0; ready = 1'b1;
    @(negedge clk);
    start = 1'b1; addr = 24'h000100; cnt = 16'd1;
    @(negedge clk);
    while (f_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    addr = 24'h000104;
    wait_done(d0 + 2, 4000, to);
    start = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout: done %0d want 2", done_cnt - d0); end
    checks++; if (gw(g0) !== 32'h44332211 || gw(g0 + 1) !== 32'h88776655) begin
      errors++; $display("FAIL b2b_words: got %h %h want 44332211 88776655", gw(g0), gw(g0 + 1)); end
    checks++; if (last_hi_run < 4) begin errors++; $display("FAIL b2b_cs_gap: csn high %0d cycles want >=4", last_hi_run); end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_clk_div3();
    test_stall();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
